// File: rtl/micro_seq_ctrl_if.sv
// Bundles the controller-side (start/abort/config/done) and datapath-side
// (t strobes, x/y flags) signals of micro_seq_ctrl.
// master = the controller/datapath driving the sequencer, slave = the sequencer.
interface micro_seq_ctrl_if #(
  parameter int AW = 4,
  parameter int NT = 9
);
  logic              start;
  logic              abort;
  logic              x;
  logic              y;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [NT+AW+1:0]  cfg_data;
  logic              cfg_rdy;
  logic [NT-1:0]     t;
  logic              busy;
  logic              done;
  logic              err;
  logic [AW-1:0]     upc;

  modport master (
    output start, abort, x, y, cfg_we, cfg_addr, cfg_data,
    input  cfg_rdy, t, busy, done, err, upc
  );

  modport slave (
    input  start, abort, x, y, cfg_we, cfg_addr, cfg_data,
    output cfg_rdy, t, busy, done, err, upc
  );
endinterface

// File: rtl/micro_seq_ctrl.sv
// Microprogrammed sequencer: steps through a writable microword table from a
// start pulse, drives the t strobes of the current word, branches on x/y and
// finishes with a one-cycle done pulse (err set on timeout or abort).
// Microword layout: {t[NT-1:0], cond[1:0], a[AW-1:0]}.
// Optional feature macro: AUTOMAT_SINGLE_STEP_EN adds a 'step' input that
// gates microprogram advance in RUN.
module micro_seq_ctrl #(
  parameter int AW      = 4,
  parameter int NT      = 9,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic res,
`ifdef AUTOMAT_SINGLE_STEP_EN
  input logic step,
`endif
  micro_seq_ctrl_if.slave bus
);

  localparam int WW    = NT + 2 + AW;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {
    COND_JMP = 2'b00,
    COND_X   = 2'b01,
    COND_Y   = 2'b10,
    COND_END = 2'b11
  } cond_t;

  localparam logic [WW-1:0] RESET_WORD = {{NT{1'b0}}, 2'b11, {AW{1'b0}}};

  state_t        state;
  logic [AW-1:0] upc;
  logic [CW-1:0] step_cnt;
  logic          err_flag;
  logic [WW-1:0] table_mem [DEPTH];

  logic [WW-1:0] word;
  logic [NT-1:0] word_t;
  cond_t         word_cond;
  logic [AW-1:0] word_a;
  logic [AW-1:0] next_upc;
  logic          advance;
  logic          timeout_hit;

  assign word      = table_mem[upc];
  assign word_t    = word[WW-1 -: NT];
  assign word_cond = cond_t'(word[AW+1 -: 2]);
  assign word_a    = word[AW-1:0];

`ifdef AUTOMAT_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = (step_cnt == CW'(TIMEOUT - 1));
    end
  endgenerate

  // Branch target for the current microword (END is handled by the FSM).
  always_comb begin
    // NOTE: default assigned first so every path drives next_upc (no latch);
    // combinational blocks use blocking '=' while clocked blocks use '<='.
    next_upc = upc + AW'(1);
    case (word_cond)
      COND_JMP: next_upc = word_a;
      COND_X:   if (bus.x) next_upc = word_a;
      COND_Y:   if (bus.y) next_upc = word_a;
      default:  ;
    endcase
  end

  // Microword table: cleared to END words on reset, writable only in IDLE.
  always_ff @(posedge clk) begin
    if (!res) begin
      // NOTE: the table is in the reset domain because a freshly reset
      // sequencer must see END in every word; this forces flops, not RAM.
      for (int i = 0; i < DEPTH; i++) table_mem[i] <= RESET_WORD;
    end else if (state == IDLE && bus.cfg_we) begin
      table_mem[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Sequencer FSM: IDLE -> RUN (one microword per advancing cycle) -> DONE.
  always_ff @(posedge clk) begin
    if (!res) begin
      state    <= IDLE;
      upc      <= '0;
      step_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            upc      <= '0;
            step_cnt <= '0;
            err_flag <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end else if (advance) begin
            if (word_cond == COND_END) begin
              err_flag <= 1'b0;
              state    <= DONE;
            end else if (timeout_hit) begin
              err_flag <= 1'b1;
              state    <= DONE;
            end else begin
              upc      <= next_upc;
              step_cnt <= step_cnt + CW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.t       = (state == RUN) ? word_t : '0;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.cfg_rdy = (state == IDLE);
  assign bus.err     = err_flag;
  assign bus.upc     = upc;

endmodule
